// File: rtl/error_status_unit.sv
// Error collector: registered priority code per operation, plus sticky status,
// first-error code, saturating count and irq, cleared through a req/ack handshake.
module error_status_unit #(
   parameter  int NUM_SRC = 3,
   parameter  int CNT_W   = 8,
   localparam int CODE_W  = $clog2(NUM_SRC + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               op_valid,
   input  logic [NUM_SRC-1:0] err_in,
   input  logic [NUM_SRC-1:0] err_mask,
   input  logic               clear_req,
   output logic               clear_ack,
   output logic [CODE_W-1:0]  err_code,
   output logic               err_valid,
   output logic [NUM_SRC-1:0] sticky,
   output logic [CODE_W-1:0]  first_code,
   output logic [CNT_W-1:0]   err_count,
   output logic               irq
);

   typedef enum logic [1:0] {IDLE, LATCHED, CLEARING} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Lowest set index wins; code is index+1, zero means no error.
   function automatic logic [CODE_W-1:0] enc(input logic [NUM_SRC-1:0] v);
      enc = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--)
         if (v[i]) enc = CODE_W'(i + 1);
   endfunction

   state_t             state, state_nxt;
   logic [NUM_SRC-1:0] m, sticky_nxt;
   logic [CODE_W-1:0]  first_nxt;
   logic [CNT_W-1:0]   count_nxt;
   logic               hit;

   assign m   = err_in & ~err_mask;
   assign hit = op_valid & (|m);

   always_comb begin
      state_nxt  = state;
      sticky_nxt = sticky;
      first_nxt  = first_code;
      count_nxt  = err_count;
      case (state)
         IDLE: begin
            if (hit) begin
               sticky_nxt = sticky | m;
               first_nxt  = enc(m);
               count_nxt  = CNT_W'(1);
               state_nxt  = LATCHED;
            end
            if (clear_req) state_nxt = CLEARING;
         end
         LATCHED: begin
            if (hit) begin
               sticky_nxt = sticky | m;
               if (err_count != CNT_MAX) count_nxt = err_count + CNT_W'(1);
            end
            if (clear_req) state_nxt = CLEARING;
         end
         CLEARING: begin
            // Status reloads from this cycle's sample so a colliding error survives.
            sticky_nxt = hit ? m : '0;
            first_nxt  = hit ? enc(m) : '0;
            count_nxt  = hit ? CNT_W'(1) : '0;
            state_nxt  = hit ? LATCHED : IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         sticky     <= '0;
         first_code <= '0;
         err_count  <= '0;
         err_code   <= '0;
         err_valid  <= 1'b0;
      end else begin
         state      <= state_nxt;
         sticky     <= sticky_nxt;
         first_code <= first_nxt;
         err_count  <= count_nxt;
         err_valid  <= op_valid;
         if (op_valid) err_code <= enc(m);
      end
   end

   assign irq       = (state == LATCHED);
   assign clear_ack = (state == CLEARING);

endmodule

// File: doc/error_status_unit.md
Name: error_status_unit

Overview:
Parametrised, clocked error collector for the calculator datapath. It samples per-operation error flags from N arithmetic units and produces a registered priority-encoded error code. It also keeps a sticky per-source status, the first error since the last clear, a saturating error counter and an interrupt line. Software or the controller clears the accumulated status through a req/ack handshake.

Parameters:
NUM_SRC, 3, number of error sources (1..15); calculator build uses src0 = divider divide-by-zero, src1 = modulo divide-by-zero, src2 = adder-subtractor overflow
CNT_W, 8, width of saturating error counter
CODE_W, $clog2(NUM_SRC+1), localparam, error code width; code 0 = no error, code k = source k-1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
op_valid  input  1  an operation result is valid this cycle; err_in is sampled only when high
err_in  input  NUM_SRC  per-source error flags for the current operation
err_mask  input  NUM_SRC  1 = source ignored (quasi-static)
clear_req  input  1  request to clear accumulated status; held until clear_ack
clear_ack  output  1  one-cycle pulse, clear performed
err_code  output  CODE_W  priority code of the last sampled operation
err_valid  output  1  one-cycle pulse, err_code updated
sticky  output  NUM_SRC  OR of all masked errors since last clear
first_code  output  CODE_W  code of the first error since last clear
err_count  output  CNT_W  number of erroring operations since last clear, saturating
irq  output  1  high while unacknowledged error is latched

Behaviour:
- Reset: asynchronous, active-low. Async assert drives all outputs to 0 and state to IDLE. Release is synchronous to clk.
- Masked errors: m = err_in & ~err_mask. Priority encoding: the lowest set index wins, code = index+1. m == 0 gives code 0.
- Latency 1. On cycle t with op_valid=1, in cycle t+1:
  - err_code = enc(m)
  - err_valid = 1, including when the code is 0
- With op_valid=0: err_code holds and err_valid=0.
- FSM states: IDLE (nothing latched), LATCHED (irq=1), CLEARING (one cycle, clear_ack=1).
- IDLE:
  - op_valid & m≠0: sticky|=m, first_code=enc(m), err_count=1, go to LATCHED.
  - clear_req: go to CLEARING.
  - Otherwise stay.
- LATCHED:
  - op_valid & m≠0: sticky|=m, err_count+=1 (saturate at 2^CNT_W-1, no wrap), first_code unchanged.
  - clear_req: go to CLEARING; an error arriving in this same cycle is accumulated and then wiped by the clear.
- CLEARING:
  - clear_ack=1 for exactly this cycle.
  - sticky, first_code and err_count load from this cycle's sample only: if op_valid & m≠0 they load m, enc(m) and 1, and the next state is LATCHED. Otherwise they load 0 and the next state is IDLE. No error presented during the clear cycle is lost.
  - err_code/err_valid path is unaffected by clear.
- Handshake: the requester drops clear_req in the cycle after it sees clear_ack. clear_req still high one cycle after the ack is a new request.
- irq = (state == LATCHED), registered. It deasserts in the CLEARING cycle.
- Changing err_mask does not retroactively alter sticky.
- Reset mid-clear: clear_ack drops immediately and all status is zero.

Test Plan:
1. Reset: rst_n=0 mid-operation with sticky=3'b101 -> all outputs 0 asynchronously, before the next clk edge; FSM in IDLE after release.
2. Priority/latency: NUM_SRC=3, op_valid=1, err_in=3'b110 -> next cycle err_code=2, err_valid=1, sticky=3'b110, first_code=2, err_count=1, irq=1. Then err_in=3'b001 -> err_code=1, sticky=3'b111, first_code stays 2, err_count=2.
3. Mask: err_mask=3'b100, err_in=3'b100 with op_valid -> err_code=0, err_valid=1, sticky=0, irq=0, err_count=0.
4. Saturation: CNT_W=4, 20 erroring operations -> err_count stops at 15 and does not wrap; irq stays 1.
5. Clear handshake: in LATCHED, clear_req=1 -> next cycle clear_ack=1 and irq=0, then sticky=0, err_count=0, first_code=0, state IDLE. clear_req dropped after ack -> no second ack.
6. Clear collision: err_in=3'b010 with op_valid during the CLEARING cycle -> after clear: sticky=3'b010, first_code=2, err_count=1, irq=1.
